// File: rtl/key_cmd_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : key_cmd_gen_if
//  Description : Button inputs and command-strobe outputs of key_cmd_gen.
//                master drives the raw keys, slave is the command generator.
//  Revision    : 1.0  initial release
// ============================================================================
interface key_cmd_gen_if;
  logic       key_in1;    // raw write button, active-low
  logic       key_in2;    // raw read button, active-low
  logic       write_en;   // one-cycle write command strobe
  logic       read_en;    // one-cycle read command strobe
  logic [1:0] key_level;  // debounced levels {key2, key1}, 1 = released

  modport master (output key_in1, key_in2, input write_en, read_en, key_level);
  modport slave  (input key_in1, key_in2, output write_en, read_en, key_level);
endinterface
`default_nettype wire

// File: rtl/key_cmd_gen.sv
`default_nettype none
// ============================================================================
//  Module      : key_cmd_gen
//  Description : Synchronises and debounces two active-low push-buttons and
//                turns each debounced press into a single-cycle command
//                strobe (key1 -> write_en, key2 -> read_en). Simultaneous
//                presses are serialised, write first.
//  Revision    : 1.0  initial release
// ============================================================================
module key_cmd_gen #(
  parameter int CNT_MAX = 1000000,
  parameter int CW      = 24
) (
  input  logic           s_clk,
  input  logic           s_rst,
  key_cmd_gen_if.slave   bus
);

  localparam logic [1:0]    c_RELEASED     = 2'd0;
  localparam logic [1:0]    c_PRESS_FILT   = 2'd1;
  localparam logic [1:0]    c_PRESSED      = 2'd2;
  localparam logic [1:0]    c_RELEASE_FILT = 2'd3;
  localparam logic [CW-1:0] c_CNT_LAST     = CW'(CNT_MAX - 1);

  logic [1:0] w_raw;   // raw key inputs, bit0 = key1, bit1 = key2
  logic [1:0] w_ev;    // press events, valid on the edge that enters PRESSED
  logic [1:0] w_lvl;   // registered debounced levels

  assign w_raw = {bus.key_in2, bus.key_in1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      logic [1:0]    r_sync;
      logic [1:0]    r_state;
      logic [CW-1:0] r_cnt;
      logic          r_level;
      logic          w_key_s;

      assign w_key_s   = r_sync[1];
      // The press event is the PRESS_FILT -> PRESSED transition itself, so
      // the arbiter registers the strobe on the same edge the level drops.
      assign w_ev[gi]  = (r_state == c_PRESS_FILT) && !w_key_s && (r_cnt == c_CNT_LAST);
      assign w_lvl[gi] = r_level;

      // Two-flop synchroniser followed by the counter-based debounce FSM.
      always_ff @(posedge s_clk) begin
        if (s_rst) begin
          r_sync  <= 2'b11;
          r_state <= c_RELEASED;
          r_cnt   <= '0;
          r_level <= 1'b1;
        end else begin
          r_sync <= {r_sync[0], w_raw[gi]};
          case (r_state)
            c_RELEASED: begin
              if (!w_key_s) begin
                r_state <= c_PRESS_FILT;
                r_cnt   <= '0;
              end
            end
            c_PRESS_FILT: begin
              if (w_key_s) begin
                r_state <= c_RELEASED;          // bounce: restart the window
                r_cnt   <= '0;
              end else if (r_cnt == c_CNT_LAST) begin
                r_state <= c_PRESSED;
                r_cnt   <= '0;
                r_level <= 1'b0;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
            c_PRESSED: begin
              if (w_key_s) begin
                r_state <= c_RELEASE_FILT;
                r_cnt   <= '0;
              end
            end
            default: begin                      // c_RELEASE_FILT
              if (!w_key_s) begin
                r_state <= c_PRESSED;           // release bounce: still held
                r_cnt   <= '0;
              end else if (r_cnt == c_CNT_LAST) begin
                r_state <= c_RELEASED;
                r_cnt   <= '0;
                r_level <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
          endcase
        end
      end
    end
  endgenerate

  logic r_pend_wr, r_pend_rd, r_write_en, r_read_en;
  logic w_want_wr, w_want_rd, w_gnt_wr, w_gnt_rd;

  // Arbiter: a pending read always goes first, otherwise write wins a tie;
  // the loser is held in its pending flag for the next cycle.
  always_comb begin
    w_want_wr = w_ev[0] | r_pend_wr;
    w_want_rd = w_ev[1] | r_pend_rd;
    w_gnt_wr  = !r_pend_rd && w_want_wr;
    w_gnt_rd  = r_pend_rd || (!w_want_wr && w_want_rd);
  end

  // Registered strobes and pending flags.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      r_write_en <= 1'b0;
      r_read_en  <= 1'b0;
      r_pend_wr  <= 1'b0;
      r_pend_rd  <= 1'b0;
    end else begin
      r_write_en <= w_gnt_wr;
      r_read_en  <= w_gnt_rd;
      r_pend_wr  <= w_want_wr && !w_gnt_wr;
      r_pend_rd  <= w_want_rd && !w_gnt_rd;
    end
  end

  assign bus.write_en  = r_write_en;
  assign bus.read_en   = r_read_en;
  assign bus.key_level = w_lvl;

endmodule
`default_nettype wire

// File: tb/tb_key_cmd_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_cmd_gen
//  Description : Directed, table-driven bench for key_cmd_gen (CNT_MAX = 16).
//                Each record holds constant inputs for a number of cycles and
//                the cycle offsets at which each strobe is expected.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_cmd_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  key_cmd_gen_if bus ();

  key_cmd_gen #(.CNT_MAX(16), .CW(24)) dut (
    .s_clk (clk),
    .s_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One segment: inputs held for len cycles; offset 0 is the first edge that
  // samples the new inputs. wr_at/rd_at = -1 means no strobe in the segment.
  typedef struct {
    logic       rst;
    logic       k1;
    logic       k2;
    int         len;
    int         wr_at;
    int         rd_at;
    int         lvl_from;
    logic [1:0] lvl;
  } seg_t;

  seg_t tbl[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic run_seg(input string name, input seg_t s);
    logic exp_wr, exp_rd;
    for (int c = 0; c < s.len; c++) begin
      rst         = s.rst;
      bus.key_in1 = s.k1;
      bus.key_in2 = s.k2;
      @(posedge clk);
      #1;
      exp_wr = (c == s.wr_at);
      exp_rd = (c == s.rd_at);
      n_total++;
      if (bus.write_en !== exp_wr) begin
        n_bad++;
        $display("FAIL %s[%0d] write_en got=%b want=%b", name, c, bus.write_en, exp_wr);
      end
      n_total++;
      if (bus.read_en !== exp_rd) begin
        n_bad++;
        $display("FAIL %s[%0d] read_en got=%b want=%b", name, c, bus.read_en, exp_rd);
      end
      n_total++;
      if (bus.write_en === 1'b1 && bus.read_en === 1'b1) begin
        n_bad++;
        $display("FAIL %s[%0d] overlap got=both want=exclusive", name, c);
      end
      if (c >= s.lvl_from) begin
        n_total++;
        if (bus.key_level !== s.lvl) begin
          n_bad++;
          $display("FAIL %s[%0d] key_level got=%b want=%b", name, c, bus.key_level, s.lvl);
        end
      end
    end
  endtask

  initial begin
    bus.key_in1 = 1'b1;
    bus.key_in2 = 1'b1;

    //                  rst   k1    k2    len  wr   rd  lvl_from lvl
    // reset and idle
    tbl.push_back(seg_t'{1'b1, 1'b1, 1'b1,   3, -1, -1,  0, 2'b11});
    tbl.push_back(seg_t'{1'b0, 1'b1, 1'b1,   5, -1, -1,  0, 2'b11});
    // clean press of key1, then release (no strobe on release)
    tbl.push_back(seg_t'{1'b0, 1'b0, 1'b1, 100, 18, -1, 18, 2'b10});
    tbl.push_back(seg_t'{1'b0, 1'b1, 1'b1,  40, -1, -1, 18, 2'b11});
    // key2 bouncing every 5 cycles for 60 cycles
    for (int i = 0; i < 6; i++) begin
      tbl.push_back(seg_t'{1'b0, 1'b1, 1'b0, 5, -1, -1, 0, 2'b11});
      tbl.push_back(seg_t'{1'b0, 1'b1, 1'b1, 5, -1, -1, 0, 2'b11});
    end
    // key2 settles low, then released
    tbl.push_back(seg_t'{1'b0, 1'b1, 1'b0,  40, -1, 18, 18, 2'b01});
    tbl.push_back(seg_t'{1'b0, 1'b1, 1'b1,  40, -1, -1, 18, 2'b11});
    // simultaneous press: write first, read one cycle later
    tbl.push_back(seg_t'{1'b0, 1'b0, 1'b0,  40, 18, 19, 18, 2'b00});
    tbl.push_back(seg_t'{1'b0, 1'b1, 1'b1,  40, -1, -1, 18, 2'b11});
    // press, short release, re-press: only the first press strobes
    tbl.push_back(seg_t'{1'b0, 1'b0, 1'b1,  40, 18, -1, 18, 2'b10});
    tbl.push_back(seg_t'{1'b0, 1'b1, 1'b1,  10, -1, -1,  0, 2'b10});
    tbl.push_back(seg_t'{1'b0, 1'b0, 1'b1,  60, -1, -1,  0, 2'b10});
    // full release then press again: second strobe
    tbl.push_back(seg_t'{1'b0, 1'b1, 1'b1,  30, -1, -1, 18, 2'b11});
    tbl.push_back(seg_t'{1'b0, 1'b0, 1'b1,  40, 18, -1, 18, 2'b10});
    tbl.push_back(seg_t'{1'b0, 1'b1, 1'b1,  40, -1, -1, 18, 2'b11});
    // reset pulse at E0+10 mid-filter; key held through reset is a fresh press
    tbl.push_back(seg_t'{1'b0, 1'b0, 1'b1,  10, -1, -1,  0, 2'b11});
    tbl.push_back(seg_t'{1'b1, 1'b0, 1'b1,   1, -1, -1,  0, 2'b11});
    tbl.push_back(seg_t'{1'b0, 1'b0, 1'b1,  40, 18, -1, 18, 2'b10});
    tbl.push_back(seg_t'{1'b0, 1'b1, 1'b1,  40, -1, -1, 18, 2'b11});

    foreach (tbl[i]) run_seg($sformatf("tbl%0d", i), tbl[i]);

    // Reset landing on the very edge the write strobe would issue.
    run_seg("rst_edge_a", seg_t'{1'b0, 1'b0, 1'b1, 18, -1, -1,  0, 2'b11});
    run_seg("rst_edge_b", seg_t'{1'b1, 1'b0, 1'b1,  1, -1, -1,  0, 2'b11});
    run_seg("rst_edge_c", seg_t'{1'b0, 1'b0, 1'b1, 40, 18, -1, 18, 2'b10});
    run_seg("rst_edge_d", seg_t'{1'b0, 1'b1, 1'b1, 40, -1, -1, 18, 2'b11});

    // Key2 leads key1 by one cycle: read first, write on the next cycle.
    run_seg("stagger_a", seg_t'{1'b0, 1'b1, 1'b0,  1, -1, -1,  0, 2'b11});
    run_seg("stagger_b", seg_t'{1'b0, 1'b0, 1'b0, 40, 18, 17, 18, 2'b00});
    run_seg("stagger_c", seg_t'{1'b0, 1'b1, 1'b1, 40, -1, -1, 19, 2'b11});

    // Trailing idle: no stray strobes.
    run_seg("idle_end", seg_t'{1'b0, 1'b1, 1'b1, 30, -1, -1,  0, 2'b11});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
